// File: rtl/reg_wr_arbiter_if.sv
// Writeback bus shared between the two requesters and the register-file write port.
// master = requester/consumer side, slave = the arbiter itself.
interface reg_wr_arbiter_if #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     req0_valid;
    logic [ADDRESS_WIDTH-1:0] req0_addr;
    logic [D_WIDTH-1:0]       req0_data;
    logic                     req0_ready;

    logic                     req1_valid;
    logic [ADDRESS_WIDTH-1:0] req1_addr;
    logic [D_WIDTH-1:0]       req1_data;
    logic                     req1_ready;

    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] a3;
    logic [D_WIDTH-1:0]       din;
    logic                     clr_busy;
    logic                     grant_id;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, a3, din, clr_busy, grant_id
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr_en, a3, din, clr_busy, grant_id
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Clears x1..x(2**ADDRESS_WIDTH-1) after reset, then arbitrates two writeback requesters
// onto the register-file write port. Define REGWR_RR_EN for round-robin instead of req0 priority.
module reg_wr_arbiter #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_wr_arbiter_if.slave bus
);
    localparam logic [ADDRESS_WIDTH-1:0] FIRST_ADDR = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = '1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] count;
    logic [ADDRESS_WIDTH-1:0] count_next;

    logic                     wr_en_q;
    logic                     wr_en_next;
    logic [ADDRESS_WIDTH-1:0] a3_q;
    logic [ADDRESS_WIDTH-1:0] a3_next;
    logic [D_WIDTH-1:0]       din_q;
    logic [D_WIDTH-1:0]       din_next;
    logic                     grant_q;
    logic                     grant_next;
    logic                     clr_busy_q;
    logic                     clr_busy_next;

    logic                     grant_valid;
    logic                     grant_sel;
    logic [ADDRESS_WIDTH-1:0] grant_addr;
    logic [D_WIDTH-1:0]       grant_data;

`ifdef REGWR_RR_EN
    logic last_grant;
    logic last_grant_next;
`endif

    // Pick at most one requester; only meaningful once the sweep has handed over to RUN.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (state == RUN) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
`ifdef REGWR_RR_EN
                grant_sel   = ~last_grant;
`else
                grant_sel   = 1'b0;
`endif
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    assign grant_addr = grant_sel ? bus.req1_addr : bus.req0_addr;
    assign grant_data = grant_sel ? bus.req1_data : bus.req0_data;

    assign bus.req0_ready = grant_valid && !grant_sel;
    assign bus.req1_ready = grant_valid &&  grant_sel;

    always_comb begin
        state_next    = state;
        count_next    = count;
        wr_en_next    = 1'b0;
        a3_next       = a3_q;
        din_next      = din_q;
        grant_next    = 1'b0;
        clr_busy_next = clr_busy_q;
`ifdef REGWR_RR_EN
        last_grant_next = last_grant;
`endif
        unique case (state)
            CLEAR: begin
                // The sweep is over once the last address has been driven; a3 still holds it.
                if (wr_en_q && (a3_q == LAST_ADDR)) begin
                    state_next    = RUN;
                    clr_busy_next = 1'b0;
                end else begin
                    wr_en_next    = 1'b1;
                    a3_next       = count;
                    din_next      = '0;
                    clr_busy_next = 1'b1;
                    if (count != LAST_ADDR) begin
                        count_next = count + ADDRESS_WIDTH'(1);
                    end
                end
            end
            RUN: begin
                clr_busy_next = 1'b0;
                if (grant_valid) begin
`ifdef REGWR_RR_EN
                    last_grant_next = grant_sel;
`endif
                    // x0 is hardwired; the request is consumed but produces no write.
                    if (grant_addr != '0) begin
                        wr_en_next = 1'b1;
                        a3_next    = grant_addr;
                        din_next   = grant_data;
                        grant_next = grant_sel;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            count      <= FIRST_ADDR;
            wr_en_q    <= 1'b0;
            a3_q       <= '0;
            din_q      <= '0;
            grant_q    <= 1'b0;
            clr_busy_q <= 1'b1;
        end else begin
            state      <= state_next;
            count      <= count_next;
            wr_en_q    <= wr_en_next;
            a3_q       <= a3_next;
            din_q      <= din_next;
            grant_q    <= grant_next;
            clr_busy_q <= clr_busy_next;
        end
    end

`ifdef REGWR_RR_EN
    // Reset value 1 makes req0 the winner of the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else begin
            last_grant <= last_grant_next;
        end
    end
`endif

    assign bus.wr_en    = wr_en_q;
    assign bus.a3       = a3_q;
    assign bus.din      = din_q;
    assign bus.grant_id = grant_q;
    assign bus.clr_busy = clr_busy_q;

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.req0_ready && bus.req1_ready));
    a_no_ready_in_sweep: assert property (@(posedge clk) disable iff (!rst_n)
        bus.clr_busy |-> !(bus.req0_ready || bus.req1_ready));
    a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
        bus.wr_en |-> (bus.a3 != '0));
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios plus randomized traffic
// against a queue-based model of the arbitration policy and a model register file.
module tb_reg_wr_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: the last address/data driven (a3/din hold these when idle),
    // expected register contents, and the requester granted most recently.
    logic [4:0]  m_a3        = '0;
    logic [31:0] m_din       = '0;
    bit          model_last  = 1'b1;
    logic [31:0] exp_rf [32];
    logic [31:0] rf     [32];

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } item_t;

    reg_wr_arbiter_if #(.D_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    reg_wr_arbiter #(.D_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Register file as the real consumer sees it: captures on the negedge, x0 hardwired.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : (32'hBAD0_0000 | i);
        forever begin
            @(negedge clk);
            if (bus.wr_en && bus.a3 != 5'd0) rf[bus.a3] = bus.din;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Arbitration rule: lone requester wins; on contention req0 (or the one not granted last).
    function automatic int pick(input bit v0, input bit v1);
        if (!v0 && !v1) return 2;
        if (v0 && !v1) return 0;
        if (!v0 && v1) return 1;
`ifdef REGWR_RR_EN
        return model_last ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    task automatic test_reset();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd4;
        bus.req0_data  = 32'hC0FF_EE04;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 5'd0;
        bus.req1_data  = 32'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy}, {1'b0, 5'd0, 32'd0, 1'b0, 1'b1});
        end
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_readies: got %b, expected 00", {bus.req0_ready, bus.req1_ready});
        end
    endtask

    task automatic test_clear_sweep();
        rst_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready}
                !== {1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 2'b00}) begin
                tests_failed++;
                $display("[TB] FAIL sweep_write_%0d: got %h, expected %h", i,
                         {bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready},
                         {1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 2'b00});
            end
        end
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
        m_a3 = 5'd31;
        m_din = 32'd0;
        model_last = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready}
            !== {1'b0, 5'd31, 32'd0, 1'b0, 1'b0, 2'b10}) begin
            tests_failed++;
            $display("[TB] FAIL sweep_end: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready},
                     {1'b0, 5'd31, 32'd0, 1'b0, 1'b0, 2'b10});
        end
        #1;
        for (int i = 0; i < 32; i++) begin
            tests_run++;
            if (rf[i] !== exp_rf[i]) begin
                tests_failed++;
                $display("[TB] FAIL sweep_cleared_x%0d: got %h, expected %h", i, rf[i], exp_rf[i]);
            end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        model_last = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id} !== {1'b1, 5'd4, 32'hC0FF_EE04, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL first_run_write: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id}, {1'b1, 5'd4, 32'hC0FF_EE04, 1'b0});
        end
        m_a3 = 5'd4;
        m_din = 32'hC0FF_EE04;
        exp_rf[4] = m_din;
    endtask

    task automatic test_req0_single();
        @(posedge clk); #1;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd5;
        bus.req0_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL single_ready: got %b, expected 10", {bus.req0_ready, bus.req1_ready});
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        model_last = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL single_write: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id}, {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0});
        end
        #1;
        tests_run++;
        if (rf[5] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("[TB] FAIL single_readback: got %h, expected deadbeef", rf[5]);
        end
        m_a3 = 5'd5;
        m_din = 32'hDEAD_BEEF;
        exp_rf[5] = m_din;
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id} !== {1'b0, m_a3, m_din, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL idle_hold: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id}, {1'b0, m_a3, m_din, 1'b0});
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] d [2];
        int w;
        int l;
        d[0] = 32'h11;
        d[1] = 32'h22;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = d[0];
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd3; bus.req1_data = d[1];
        @(negedge clk);
        w = pick(1'b1, 1'b1);
        l = 1 - w;
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== {w == 0, w == 1}) begin
            tests_failed++;
            $display("[TB] FAIL same_addr_first_ready: got %b, expected %b",
                     {bus.req0_ready, bus.req1_ready}, {w == 0, w == 1});
        end
        @(posedge clk); #1;
        if (w == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        model_last = 1'(w);
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.req0_ready, bus.req1_ready}
            !== {1'b1, 5'd3, d[w], 1'(w), l == 0, l == 1}) begin
            tests_failed++;
            $display("[TB] FAIL same_addr_first_write: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.req0_ready, bus.req1_ready},
                     {1'b1, 5'd3, d[w], 1'(w), l == 0, l == 1});
        end
        @(posedge clk); #1;
        if (l == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        model_last = 1'(l);
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id} !== {1'b1, 5'd3, d[l], 1'(l)}) begin
            tests_failed++;
            $display("[TB] FAIL same_addr_second_write: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id}, {1'b1, 5'd3, d[l], 1'(l)});
        end
        #1;
        tests_run++;
        if (rf[3] !== d[l]) begin
            tests_failed++;
            $display("[TB] FAIL same_addr_final: got %h, expected %h", rf[3], d[l]);
        end
        m_a3 = 5'd3;
        m_din = d[l];
        exp_rf[3] = d[l];
    endtask

    task automatic test_contention();
        logic [31:0] d0 [4];
        logic [31:0] d1 [4];
        int k0 = 0;
        int k1 = 0;
        int w;
        bit exp_we = 1'b0;
        bit exp_g  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d0[i] = $urandom;
            d1[i] = $urandom;
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            bus.req0_valid = (k0 < 4);
            if (k0 < 4) begin bus.req0_addr = 5'(10 + k0); bus.req0_data = d0[k0]; end
            bus.req1_valid = (k1 < 4);
            if (k1 < 4) begin bus.req1_addr = 5'(20 + k1); bus.req1_data = d1[k1]; end
            @(negedge clk);
            tests_run++;
            if ({bus.wr_en, bus.a3, bus.din, bus.grant_id} !== {exp_we, m_a3, m_din, exp_g}) begin
                tests_failed++;
                $display("[TB] FAIL contention_write_c%0d: got %h, expected %h", c,
                         {bus.wr_en, bus.a3, bus.din, bus.grant_id}, {exp_we, m_a3, m_din, exp_g});
            end
            w = pick(bus.req0_valid, bus.req1_valid);
            tests_run++;
            if ({bus.req0_ready, bus.req1_ready} !== {w == 0, w == 1}) begin
                tests_failed++;
                $display("[TB] FAIL contention_ready_c%0d: got %b, expected %b", c,
                         {bus.req0_ready, bus.req1_ready}, {w == 0, w == 1});
            end
            exp_we = 1'b0;
            exp_g  = 1'b0;
            if (w == 0) begin
                model_last = 1'b0; exp_we = 1'b1; exp_g = 1'b0;
                m_a3 = 5'(10 + k0); m_din = d0[k0]; exp_rf[m_a3] = m_din; k0++;
            end else if (w == 1) begin
                model_last = 1'b1; exp_we = 1'b1; exp_g = 1'b1;
                m_a3 = 5'(20 + k1); m_din = d1[k1]; exp_rf[m_a3] = m_din; k1++;
            end
            if (k0 == 4 && k1 == 4 && !exp_we) break;
        end
    endtask

    task automatic test_addr_zero();
        @(posedge clk); #1;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 5'd0;
        bus.req1_data  = 32'h55;
        @(negedge clk);
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL addr0_ready: got %b, expected 01", {bus.req0_ready, bus.req1_ready});
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id} !== {1'b0, m_a3, m_din, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL addr0_dropped: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id}, {1'b0, m_a3, m_din, 1'b0});
        end
        #1;
        tests_run++;
        if (rf[0] !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL addr0_x0: got %h, expected 0", rf[0]);
        end
    endtask

    task automatic test_random();
        item_t q0 [$];
        item_t q1 [$];
        item_t it;
        int    w;
        bit    acc0   = 1'b0;
        bit    acc1   = 1'b0;
        bit    exp_we = 1'b0;
        bit    exp_g  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            it.addr = 5'($urandom_range(0, 8));
            it.data = $urandom;
            q0.push_back(it);
            it.addr = 5'($urandom_range(0, 8));
            it.data = $urandom;
            q1.push_back(it);
        end
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (acc0) bus.req0_valid = 1'b0;
            if (acc1) bus.req1_valid = 1'b0;
            acc0 = 1'b0;
            acc1 = 1'b0;
            if (!bus.req0_valid && q0.size() > 0 && $urandom_range(0, 3) != 0) begin
                bus.req0_valid = 1'b1; bus.req0_addr = q0[0].addr; bus.req0_data = q0[0].data;
            end
            if (!bus.req1_valid && q1.size() > 0 && $urandom_range(0, 3) != 0) begin
                bus.req1_valid = 1'b1; bus.req1_addr = q1[0].addr; bus.req1_data = q1[0].data;
            end
            @(negedge clk);
            tests_run++;
            if ({bus.wr_en, bus.a3, bus.din, bus.grant_id} !== {exp_we, m_a3, m_din, exp_g}) begin
                tests_failed++;
                $display("[TB] FAIL random_write_c%0d: got %h, expected %h", c,
                         {bus.wr_en, bus.a3, bus.din, bus.grant_id}, {exp_we, m_a3, m_din, exp_g});
            end
            w = pick(bus.req0_valid, bus.req1_valid);
            tests_run++;
            if ({bus.req0_ready, bus.req1_ready} !== {w == 0, w == 1}) begin
                tests_failed++;
                $display("[TB] FAIL random_ready_c%0d: got %b, expected %b", c,
                         {bus.req0_ready, bus.req1_ready}, {w == 0, w == 1});
            end
            exp_we = 1'b0;
            exp_g  = 1'b0;
            if (w != 2) begin
                if (w == 0) begin it = q0.pop_front(); acc0 = 1'b1; end
                else        begin it = q1.pop_front(); acc1 = 1'b1; end
                model_last = 1'(w);
                if (it.addr != 5'd0) begin
                    exp_we = 1'b1;
                    exp_g  = 1'(w);
                    m_a3   = it.addr;
                    m_din  = it.data;
                    exp_rf[it.addr] = it.data;
                end
            end
            if (q0.size() == 0 && q1.size() == 0 && !acc0 && !acc1 && !exp_we
                && !bus.req0_valid && !bus.req1_valid) break;
        end
        #1;
        for (int i = 0; i < 32; i++) begin
            tests_run++;
            if (rf[i] !== exp_rf[i]) begin
                tests_failed++;
                $display("[TB] FAIL random_regfile_x%0d: got %h, expected %h", i, rf[i], exp_rf[i]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [31:0] pend;
        pend = $urandom;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd17;
        bus.req0_data  = pend;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready}
            !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'b00}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_run: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready},
                     {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'b00});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.wr_en, bus.a3, bus.clr_busy, bus.req0_ready} !== {1'b1, 5'(i), 1'b1, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL partial_sweep_%0d: got %h, expected %h", i,
                         {bus.wr_en, bus.a3, bus.clr_busy, bus.req0_ready}, {1'b1, 5'(i), 1'b1, 1'b0});
            end
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready}
            !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'b00}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_sweep: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready},
                     {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'b00});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready}
                !== {1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 2'b00}) begin
                tests_failed++;
                $display("[TB] FAIL resweep_write_%0d: got %h, expected %h", i,
                         {bus.wr_en, bus.a3, bus.din, bus.grant_id, bus.clr_busy, bus.req0_ready, bus.req1_ready},
                         {1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 2'b00});
            end
        end
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
        model_last = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.clr_busy, bus.req0_ready, bus.req1_ready} !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL resweep_end: got %b, expected 0010",
                     {bus.wr_en, bus.clr_busy, bus.req0_ready, bus.req1_ready});
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        model_last = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.wr_en, bus.a3, bus.din, bus.grant_id} !== {1'b1, 5'd17, pend, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL held_request_write: got %h, expected %h",
                     {bus.wr_en, bus.a3, bus.din, bus.grant_id}, {1'b1, 5'd17, pend, 1'b0});
        end
        exp_rf[17] = pend;
        #1;
        for (int i = 0; i < 32; i++) begin
            tests_run++;
            if (rf[i] !== exp_rf[i]) begin
                tests_failed++;
                $display("[TB] FAIL resweep_regfile_x%0d: got %h, expected %h", i, rf[i], exp_rf[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_req0_single();
        test_same_addr();
        test_contention();
        test_addr_zero();
        test_random();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Shares the single register-file write port (wr_en/a3/din) between two writeback requesters: req0 (ALU writeback) and req1 (load/multi-cycle unit writeback). After reset it first runs a clear sweep that writes zero to x1..x31, so register contents are deterministic without relying on simulation initialisation. It then arbitrates requests with a valid/ready handshake and drives one registered write per cycle into reg_file.

## Interface
- D_WIDTH, 32, register data width
- ADDRESS_WIDTH, 5, register address width; sweep covers 1..2**ADDRESS_WIDTH-1
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  ALU writeback request
- req0_addr  in  ADDRESS_WIDTH  destination register
- req0_data  in  D_WIDTH  write data
- req0_ready  out  1  req0 accepted this cycle (combinational)
- req1_valid / req1_addr / req1_data / req1_ready  same as req0, for the load/multi-cycle unit
- wr_en  out  1  to reg_file wr_en (registered)
- a3  out  ADDRESS_WIDTH  to reg_file a3 (registered)
- din  out  D_WIDTH  to reg_file din (registered)
- clr_busy  out  1  clear sweep in progress (registered)
- grant_id  out  1  requester whose write is on wr_en this cycle; 0 when wr_en is from the sweep or low

## Operation
- FSM states:
  - CLEAR: entered on reset. Counter runs 1..31. Drives wr_en=1, a3=count, din=0 each cycle. Both readies are 0. After count 31 is issued, go to RUN.
  - RUN: arbitration.
- Arbitration in RUN:
  - Exactly one of req0_ready/req1_ready is high per cycle, and only if its valid is high.
  - Default policy is fixed priority: req0 wins over req1.
  - Handshake: transfer occurs when valid && ready at posedge.
  - Requester holds valid, addr and data stable until it sees ready. No ready-to-valid dependency on the requester side.
- On transfer: the next cycle drives wr_en=1, a3=addr, din=data, grant_id=winner.
- No transfer: wr_en=0; a3 and din hold their previous values.
- Address 0: the request is accepted (ready high) but dropped; wr_en stays 0 for that slot.
- Both requesters valid with the same address: each write is issued in grant order. The register ends with the value of the later-granted request.
- Starvation: with fixed priority, req1 can starve while req0 is continuously valid. This is allowed; the pipeline guarantees req0 gaps.

## Timing
- Reset values: wr_en=0, a3=0, din=0, grant_id=0, clr_busy=1, req0_ready=0, req1_ready=0, state=CLEAR, count=1.
- Clear sweep after rst_n deassertion:
  - First sweep write appears in the first posedge-updated cycle.
  - 31 consecutive cycles of wr_en=1, with clr_busy=1 throughout.
  - clr_busy falls in the same cycle readies may first rise.
- Write latency: accept at posedge N → wr_en/a3/din valid from posedge N until N+1. reg_file captures it at the intervening negedge, so the written value is readable combinationally after that negedge.
- Throughput: 1 write per cycle. With both requesters valid, the loser waits one cycle per winning grant.
- Reset asserted mid-sweep or mid-RUN: all outputs return to reset values immediately (asynchronous). The sweep restarts from x1 after release. In-flight un-accepted requests are not lost; the requester keeps valid.
- Counter width is ADDRESS_WIDTH. The sweep stops at all-ones and does not wrap.

## Configuration
- REGWR_RR_EN defined: round-robin arbitration.
  - A 1-bit last_grant register, reset to 1, so req0 wins the first contention.
  - On contention, the requester not granted last wins.
  - An uncontended grant also updates last_grant.
- REGWR_RR_EN undefined: fixed priority, req0 > req1; no last_grant register.

## Test plan
- Reset release, no requests: 31 cycles of wr_en=1 with a3=1..31 and din=0, clr_busy=1. Then clr_busy=0 and wr_en=0 the next cycle.
- In RUN, req0 only: addr=5, data=0xDEADBEEF → req0_ready=1. Next cycle: wr_en=1, a3=5, din=0xDEADBEEF, grant_id=0. A read of x5 returns 0xDEADBEEF after the negedge.
- Both valid, req0 addr=3 data=0x11 and req1 addr=3 data=0x22, fixed priority:
  - Cycle 1 grants req0; cycle 2 grants req1.
  - x3 ends at 0x22; grant_id sequence is 0 then 1.
- With REGWR_RR_EN, both requesters valid for 4 cycles with distinct addresses: grants alternate 0,1,0,1.
- req1 addr=0 data=0x55 → req1_ready=1, wr_en stays 0, x0 remains 0.
- Assert rst_n low at sweep count 10, release after 2 cycles: outputs go to reset values during reset. The sweep restarts at a3=1 and completes all 31 writes.
